// File: rtl/tick_sched_pkg.sv
// Shared encodings for the tick-driven byte scheduler: tick ratio selects and source ids.
package tick_sched_pkg;

  localparam logic [1:0] DIV_2  = 2'd0;
  localparam logic [1:0] DIV_4  = 2'd1;
  localparam logic [1:0] DIV_8  = 2'd2;
  localparam logic [1:0] DIV_16 = 2'd3;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection; prio names the winner only when both request.
module rr_arbiter2
  import tick_sched_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic prio,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  always_comb begin
    gnt_a = en & valid_a & (~valid_b | (prio == SRC_A));
    gnt_b = en & valid_b & (~valid_a | (prio == SRC_B));
  end

endmodule

// File: rtl/tick_byte_scheduler.sv
// Shares one registered byte lane between two requesters, arbitrating only on a
// periodic tick whose ratio is selectable.
module tick_byte_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] div_sel,
  input  logic       req_a_valid,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       out_src,
  output logic       tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tick_mask;
  logic [1:0]       div_act_q;
  logic             prio_q;
  logic [7:0]       out_byte_q;
  logic             out_valid_q;
  logic             out_src_q;
  logic             gnt_a;
  logic             gnt_b;
  logic             xfer_a;
  logic             xfer_b;

  // Tick fires when the low div_act+1 counter bits are all ones.
  always_comb begin
    tick_mask = '0;
    for (int i = 0; i < int'(CNT_W); i++) begin
      tick_mask[i] = (i <= int'(div_act_q));
    end
    tick = (&(cnt_q | ~tick_mask)) & reset;
  end

  rr_arbiter2 u_arb (
    .valid_a (req_a_valid),
    .valid_b (req_b_valid),
    .prio    (prio_q),
    .en      (tick),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  always_comb begin
    req_a_ready = tick & gnt_a;
    req_b_ready = tick & gnt_b;
    xfer_a      = req_a_valid & req_a_ready;
    xfer_b      = req_b_valid & req_b_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      div_act_q   <= DIV_2;
      prio_q      <= SRC_A;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_src_q   <= SRC_A;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (tick) begin
        div_act_q <= div_sel;
        if (xfer_a || xfer_b) begin
          out_byte_q  <= xfer_b ? req_b_data : req_a_data;
          out_valid_q <= 1'b1;
          out_src_q   <= xfer_b ? SRC_B : SRC_A;
          prio_q      <= xfer_b ? SRC_A : SRC_B;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/tick_byte_scheduler.md
TICK_BYTE_SCHEDULER -- requirements
Module: tick_byte_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 4, meaning width of the free-running tick counter (maximum divide ratio 2^CNT_W).
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset: assertion (low) clears all state immediately, independent of clk.
REQ-004 SHALL have port div_sel, input, 2, tick ratio select: 0=/2, 1=/4, 2=/8, 3=/16.
REQ-005 SHALL have ports req_a_valid (input, 1) and req_a_data (input, 8), requester A offer.
REQ-006 SHALL have port req_a_ready, output, 1, grant/accept to requester A.
REQ-007 SHALL have ports req_b_valid, req_b_data and req_b_ready, identical in function to the requester A ports.
REQ-008 SHALL have port out_byte, output, 8, registered shared byte lane.
REQ-009 SHALL have port out_valid, output, 1, out_byte was loaded on the most recent tick.
REQ-010 SHALL have port out_src, output, 1, source of out_byte (0=A, 1=B).
REQ-011 SHALL have port tick, output, 1, one-clk-wide scheduling strobe.

Function
REQ-012 SHALL use a counter cnt[CNT_W-1:0] that increments by 1 on every clk and wraps from all-ones to 0.
REQ-013 SHALL use an active ratio register div_act, loaded from div_sel on every tick cycle and held otherwise.
REQ-014 SHALL assert tick combinationally when cnt bits [div_act:0] are all ones (period 2, 4, 8 or 16 clk).
REQ-015 SHALL consider arbitration only in tick cycles; in non-tick cycles req_a_ready and req_b_ready SHALL both be 0.
REQ-016 SHALL grant, in a tick cycle, the only valid requester when exactly one is valid.
REQ-017 SHALL grant, in a tick cycle with both requesters valid, the requester named by the round-robin pointer prio (0=A, 1=B).
REQ-018 SHALL drive ready combinationally: req_x_ready = tick AND grant_x; at most one ready SHALL be high in any cycle.
REQ-019 SHALL treat a transfer as complete when valid and ready are both high in the same cycle.
REQ-020 SHALL, on the clk after a transfer, load out_byte with the granted data, set out_valid=1 and set out_src to the grantee (latency 1 clk).
REQ-021 SHALL, after a transfer, set prio to the requester not granted; prio SHALL be unchanged when no transfer occurs.
REQ-022 SHALL, on a tick cycle with no valid requester, clear out_valid and hold out_byte and out_src.
REQ-023 SHALL hold out_byte, out_valid and out_src in non-tick cycles.
REQ-024 SHALL allow requesters to change data or drop valid between ticks without effect; only values at the tick cycle are sampled.
REQ-025 SHALL take effect of a div_sel change at the next tick only; the tick in progress uses the old ratio.

Reset
REQ-026 SHALL set, while reset is low: cnt=0, div_act=0, prio=0 (A), out_byte=8'h00, out_valid=0, out_src=0.
REQ-027 SHALL force req_a_ready, req_b_ready and tick to 0 while reset is low.
REQ-028 SHALL restart the first tick 2^(div_act+1) clk after reset deasserts, i.e. with div_act=0, tick occurs on the 2nd clk.
REQ-029 SHALL discard an in-progress grant when reset is asserted mid-tick; no out_byte update occurs.

Structure
REQ-030 SHALL place the div_sel encodings and the source encodings (SRC_A=0, SRC_B=1) in the shared package tick_sched_pkg.
REQ-031 SHALL implement grant selection in one sub-module rr_arbiter2 (inputs: two valids, prio, en; outputs: two one-hot grants); the counter and output registers reside in the top module.

Verification
REQ-032 SHALL cover: div_sel=0, A valid 8'h5A held -> tick every 2 clk, out_byte=8'h5A, out_src=0 one clk after each ready.
REQ-033 SHALL cover: both valid (A=8'h11, B=8'h22), div_sel=1 -> out_byte alternates 11,22,11,... every 4 clk, with A first after reset.
REQ-034 SHALL cover: no valid at a tick -> out_valid=0 and out_byte retains its last value.
REQ-035 SHALL cover: div_sel switched from 3 to 0 mid-period -> current /16 tick completes, subsequent ticks at /2.
REQ-036 SHALL cover: reset driven low between clk edges during a grant -> all outputs immediately at their reset values, prio=A.
REQ-037 SHALL cover: valid pulsed only between ticks -> no ready, no transfer, outputs unchanged.
